// File: rtl/pps_time_counter_if.sv
// pps_time_counter_if
//   Bundles the PPS strobe, the seconds-load request and every time/lock
//   status output of pps_time_counter.
//   master : drives pps_in / sec_load_*, observes the time and status outputs
//   slave  : the counter itself
//   Signals:
//     pps_in          single-cycle PPS strobe, synchronous to ptp_clk
//     sec_load_valid  one-cycle request to load the seconds count
//     sec_load_data   seconds value applied at the next second boundary
//     sec_out         seconds count
//     subsec_out      cycles since the last second boundary
//     tick_out        one-cycle pulse per second boundary
//     locked          counter is locked to PPS
//     holdover        PPS lost, counter free-running from its locked phase
//     pps_interval    last measured PPS-to-PPS interval in cycles
//     interval_valid  one-cycle pulse when pps_interval updates
interface pps_time_counter_if #(
  parameter int C_SEC_WIDTH = 32
);
  logic                   pps_in;
  logic                   sec_load_valid;
  logic [C_SEC_WIDTH-1:0] sec_load_data;
  logic [C_SEC_WIDTH-1:0] sec_out;
  logic [31:0]            subsec_out;
  logic                   tick_out;
  logic                   locked;
  logic                   holdover;
  logic [31:0]            pps_interval;
  logic                   interval_valid;

  modport master (
    output pps_in, sec_load_valid, sec_load_data,
    input  sec_out, subsec_out, tick_out, locked, holdover,
           pps_interval, interval_valid
  );

  modport slave (
    input  pps_in, sec_load_valid, sec_load_data,
    output sec_out, subsec_out, tick_out, locked, holdover,
           pps_interval, interval_valid
  );
endinterface

// File: rtl/pps_time_counter.sv
// pps_time_counter
//   Seconds / sub-seconds time counter disciplined by a PPS strobe. A four
//   state lock machine (UNLOCKED, LOCKING, LOCKED, HOLDOVER) decides on each
//   cycle whether the second boundary comes from the PPS or from the local
//   free-running count. All outputs are registered.
//   Ports:
//     ptp_clk   sole clock
//     ptp_rstn  asynchronous active-low reset
//     bus       pps_time_counter_if.slave (PPS in, seconds load, time/status out)
//   Parameters:
//     C_CLOCK_FREQUENCY  ptp_clk frequency in kHz (one second = value*1000 cycles)
//     C_TOLERANCE        accepted PPS interval deviation in cycles
//     C_LOCK_COUNT       consecutive in-window PPS needed to lock
//     C_SEC_WIDTH        seconds counter width
//   Build option:
//     PPS_TIME_COUNTER_INTERVAL_EN  when defined, the PPS-to-PPS interval
//     measurement is compiled in; otherwise pps_interval/interval_valid are 0.
module pps_time_counter #(
  parameter int C_CLOCK_FREQUENCY = 25000,
  parameter int C_TOLERANCE       = 2500,
  parameter int C_LOCK_COUNT      = 3,
  parameter int C_SEC_WIDTH       = 32
) (
  input  logic              ptp_clk,
  input  logic              ptp_rstn,
  pps_time_counter_if.slave bus
);

  localparam logic [31:0] N_CYC    = 32'(C_CLOCK_FREQUENCY * 1000);
  localparam logic [31:0] TOL      = 32'(C_TOLERANCE);
  localparam logic [31:0] LAST_CYC = N_CYC - 32'd1;
  localparam logic [31:0] WIN_LO   = LAST_CYC - TOL;
  localparam logic [31:0] WIN_HI   = LAST_CYC + TOL - 32'd1;
  localparam logic [31:0] TIMEOUT  = LAST_CYC + TOL;
  localparam logic [31:0] HO_LATE  = N_CYC - TOL;
  localparam int          CNT_W    = $clog2(C_LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LOCK_TARGET = CNT_W'(C_LOCK_COUNT);

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED, HOLDOVER} state_t;

  // What the time counter does on this edge.
  //   ACT_RUN      subsec += 1
  //   ACT_BOUNDARY second boundary: subsec 0, tick, seconds advance
  //   ACT_HOLDOVER PPS lost: tick and seconds advance, subsec restarts at the
  //                tolerance so the phase stays where the PPS was expected
  //   ACT_REPHASE  PPS arrived just after a free-run boundary in holdover:
  //                pull subsec back to 0 without a second tick
  typedef enum logic [1:0] {ACT_RUN, ACT_BOUNDARY, ACT_HOLDOVER, ACT_REPHASE} act_t;
  typedef enum logic [1:0] {CNT_KEEP, CNT_CLEAR, CNT_INC} cnt_op_t;

  state_t                 state_q, state_d;
  act_t                   act;
  cnt_op_t                cnt_op;
  logic [CNT_W-1:0]       lock_cnt_q;
  logic [31:0]            subsec_q, subsec_d;
  logic [C_SEC_WIDTH-1:0] sec_q, sec_d;
  logic                   tick_q, tick_d;
  logic                   locked_q, locked_d;
  logic                   holdover_q, holdover_d;
  logic                   pend_valid_q;
  logic [C_SEC_WIDTH-1:0] pend_data_q;
  logic                   in_window;

  assign in_window = (subsec_q >= WIN_LO) && (subsec_q <= WIN_HI);

  always_ff @(posedge ptp_clk or negedge ptp_rstn) begin
    if (!ptp_rstn) begin
      state_q <= UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // PPS always takes priority over the local timeout/free-run checks, so a
  // PPS landing exactly on the timeout cycle is treated as out-of-window.
  always_comb begin
    state_d = state_q;
    act     = ACT_RUN;
    cnt_op  = CNT_KEEP;
    case (state_q)
      UNLOCKED: begin
        if (bus.pps_in) begin
          act     = ACT_BOUNDARY;
          state_d = LOCKING;
          cnt_op  = CNT_CLEAR;
        end else if (subsec_q == LAST_CYC) begin
          act = ACT_BOUNDARY;
        end
      end
      LOCKING: begin
        if (bus.pps_in) begin
          act = ACT_BOUNDARY;
          if (in_window) begin
            cnt_op = CNT_INC;
            if ((lock_cnt_q + 1'b1) == LOCK_TARGET) begin
              state_d = LOCKED;
            end
          end else begin
            cnt_op = CNT_CLEAR;
          end
        end else if (subsec_q == TIMEOUT) begin
          act     = ACT_BOUNDARY;
          state_d = UNLOCKED;
        end
      end
      LOCKED: begin
        if (bus.pps_in) begin
          act = ACT_BOUNDARY;
          if (!in_window) begin
            state_d = LOCKING;
            cnt_op  = CNT_CLEAR;
          end
        end else if (subsec_q == TIMEOUT) begin
          act     = ACT_HOLDOVER;
          state_d = HOLDOVER;
        end
      end
      HOLDOVER: begin
        if (bus.pps_in) begin
          if (subsec_q >= HO_LATE) begin
            act     = ACT_BOUNDARY;
            state_d = LOCKED;
          end else if (subsec_q < TOL) begin
            act     = ACT_REPHASE;
            state_d = LOCKED;
          end else begin
            act     = ACT_BOUNDARY;
            state_d = LOCKING;
            cnt_op  = CNT_CLEAR;
          end
        end else if (subsec_q == LAST_CYC) begin
          act = ACT_BOUNDARY;
        end
      end
      default: begin
        state_d = UNLOCKED;
      end
    endcase
  end

  // Next values of the registered outputs. Any tick consumes a pending
  // seconds load instead of incrementing.
  always_comb begin
    subsec_d   = subsec_q + 32'd1;
    sec_d      = sec_q;
    tick_d     = 1'b0;
    locked_d   = (state_d == LOCKED);
    holdover_d = (state_d == HOLDOVER);
    case (act)
      ACT_BOUNDARY: begin
        subsec_d = '0;
        tick_d   = 1'b1;
        sec_d    = pend_valid_q ? pend_data_q : sec_q + 1'b1;
      end
      ACT_HOLDOVER: begin
        subsec_d = TOL;
        tick_d   = 1'b1;
        sec_d    = pend_valid_q ? pend_data_q : sec_q + 1'b1;
      end
      ACT_REPHASE: begin
        subsec_d = '0;
      end
      default: begin
        subsec_d = subsec_q + 32'd1;
      end
    endcase
  end

  // A load request arriving on a tick edge is kept for the following tick,
  // because the tick itself consumed the previous pending value.
  always_ff @(posedge ptp_clk or negedge ptp_rstn) begin
    if (!ptp_rstn) begin
      subsec_q     <= '0;
      sec_q        <= '0;
      tick_q       <= 1'b0;
      locked_q     <= 1'b0;
      holdover_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      lock_cnt_q   <= '0;
    end else begin
      subsec_q   <= subsec_d;
      sec_q      <= sec_d;
      tick_q     <= tick_d;
      locked_q   <= locked_d;
      holdover_q <= holdover_d;
      if (bus.sec_load_valid) begin
        pend_valid_q <= 1'b1;
        pend_data_q  <= bus.sec_load_data;
      end else if (tick_d) begin
        pend_valid_q <= 1'b0;
      end
      case (cnt_op)
        CNT_CLEAR: lock_cnt_q <= '0;
        CNT_INC:   lock_cnt_q <= lock_cnt_q + 1'b1;
        default:   lock_cnt_q <= lock_cnt_q;
      endcase
    end
  end

  assign bus.sec_out    = sec_q;
  assign bus.subsec_out = subsec_q;
  assign bus.tick_out   = tick_q;
  assign bus.locked     = locked_q;
  assign bus.holdover   = holdover_q;

`ifdef PPS_TIME_COUNTER_INTERVAL_EN
  logic [31:0] ivl_cnt_q;
  logic [31:0] ivl_q;
  logic        ivl_valid_q;
  logic        seen_pps_q;

  // ivl_cnt_q equals the number of edges since the last PPS when sampled on
  // the next PPS edge. The first PPS after reset only arms the measurement.
  always_ff @(posedge ptp_clk or negedge ptp_rstn) begin
    if (!ptp_rstn) begin
      ivl_cnt_q   <= '0;
      ivl_q       <= '0;
      ivl_valid_q <= 1'b0;
      seen_pps_q  <= 1'b0;
    end else if (bus.pps_in) begin
      ivl_cnt_q   <= 32'd1;
      ivl_valid_q <= seen_pps_q;
      seen_pps_q  <= 1'b1;
      if (seen_pps_q) begin
        ivl_q <= ivl_cnt_q;
      end
    end else begin
      ivl_valid_q <= 1'b0;
      if (ivl_cnt_q != '1) begin
        ivl_cnt_q <= ivl_cnt_q + 32'd1;
      end
    end
  end

  assign bus.pps_interval   = ivl_q;
  assign bus.interval_valid = ivl_valid_q;
`else
  assign bus.pps_interval   = '0;
  assign bus.interval_valid = 1'b0;
`endif

endmodule
